mem_stage: RTL
==============

# mem_stage

Memory-access stage of the five-stage LoongArch pipeline, between the execute stage and write-back. Latches the execute-to-memory bus and collects the synchronous data-SRAM read word, which is valid only in the cycle after the address. Holds that word across write-back stalls, extracts and extends the ld.b/bu/h/hu/w result, and forwards the final register value to decode for RAW bypass.

## Interface
- EXE_TO_MEM_BUS_WD, 78, width of incoming bus
- MEM_TO_WB_BUS_WD, 70, width of outgoing bus
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- exe_to_mem_valid  input  1  execute stage offers an instruction
- exe_to_mem_bus  input  78  [77]ld_b [76]ld_bu [75]ld_h [74]ld_hu [73]ld_w [72]signed_option [71]lu12i_w [70]load_op [69]gr_we [68:64]dest [63:32]alu_result [31:0]pc
- mem_allowin  output  1  stage can accept an instruction this cycle
- wb_allowin  input  1  write-back accepts this cycle
- mem_to_wb_valid  output  1  instruction offered to write-back
- mem_to_wb_bus  output  70  [69]gr_we [68:64]dest [63:32]final_result [31:0]pc
- data_sram_rdata  input  32  SRAM read data, one cycle after the address
- gr_we_mem  output  1  gr_we when stage valid, else 0
- dest_mem  output  5  dest when stage valid, else 0
- forward_data_mem  output  32  final_result when stage valid, else 0

## Operation
- Registers: mem_valid, bus_reg (78b), rdata_buf (32b), and a 2-bit state for the read word:
  - EMPTY: no instruction, or non-load.
  - FRESH: first cycle of a load in stage; the read word is on data_sram_rdata.
  - HELD: load stalled past its first cycle; the read word is in rdata_buf.
- Accept = exe_to_mem_valid & mem_allowin. On accept, bus_reg <= exe_to_mem_bus. State then goes to FRESH if the incoming load_op=1, else EMPTY.
- mem_valid <= exe_to_mem_valid when mem_allowin=1; otherwise it holds.
- Leaving FRESH:
  - No accept that cycle: state -> HELD and rdata_buf <= data_sram_rdata.
  - Accept that cycle: the next state comes from the new instruction.
- HELD persists until a new accept. rdata_buf changes only on the FRESH -> HELD transition.
- raw_word = (state==FRESH) ? data_sram_rdata : rdata_buf.
- Lane select, with a = alu_result[1:0]:
  - byte = raw_word[8a+7:8a]
  - half = alu_result[1] ? raw_word[31:16] : raw_word[15:0]; alu_result[0] is ignored for halves.
- load_data:
  - ld_b: sign-extend byte; ld_bu: zero-extend byte.
  - ld_h: sign-extend half; ld_hu: zero-extend half.
  - ld_w: raw_word.
  - No load one-hot set: raw_word.
- final_result = load_op ? load_data : alu_result. The lu12i_w and signed_option fields are consumed and not used further; alu_result already holds the value for lu12i.w.
- ready_go is always 1. mem_allowin = !mem_valid | wb_allowin. mem_to_wb_valid = mem_valid.

## Timing
- After reset: mem_valid=0, state=EMPTY, rdata_buf=0, mem_allowin=1, mem_to_wb_valid=0, gr_we_mem=0, dest_mem=0, forward_data_mem=0. mem_to_wb_bus is don't-care while invalid.
- Latency: a non-stalled instruction is in MEM exactly 1 cycle.
  - For a load, final_result is valid combinationally in that cycle from data_sram_rdata.
  - Forward data is valid in the same cycle; decode does not need to stall on a load that has reached MEM.
- Stall: while wb_allowin=0, mem_allowin=0. bus_reg, mem_valid and the forward outputs are stable every stalled cycle. For a load, final_result stays equal to its first-cycle value even if data_sram_rdata changes.
- Simultaneous leave and accept (mem_valid & wb_allowin & exe_to_mem_valid): the new instruction replaces the old one in one cycle, with no bubble.
- Back-to-back loads: each load uses its own FRESH word; rdata_buf is never read in FRESH.
- Reset asserted mid-stall or in FRESH: next cycle mem_valid=0 and state=EMPTY; the pending instruction is discarded.

## Test plan
- ld.w at addr 0x100, rdata=0x8899AABB, wb_allowin=1 -> next cycle: mem_to_wb_valid=1, final_result=0x8899AABB, forward_data_mem=0x8899AABB, dest_mem=dest.
- Byte and half extraction on rdata=0x80F17F02:
  - ld.b, addr low bits 2'b10 -> 0xFFFFFFF1
  - ld.bu, addr low bits 2'b10 -> 0x000000F1
  - ld.h, addr low bits 2'b10 -> 0xFFFF80F1
  - ld.hu, addr low bits 2'b00 -> 0x00007F02
  - ld.h, addr low bits 2'b11 -> 0xFFFF80F1 (bit0 ignored)
- ld.w with rdata=0x12345678 in the first cycle, then wb_allowin=0 for 3 cycles while rdata changes to 0xDEADBEEF -> final_result stays 0x12345678 throughout; it leaves on the cycle wb_allowin=1.
- add.w result 0x5, gr_we=1, dest=7, followed back-to-back by ld.bu from addr 0x3 with rdata=0xAB000000 -> cycle 1 forward 0x5/dest 7, cycle 2 forward 0x000000AB; no bubble, mem_allowin=1 throughout.
- wb_allowin=0 with mem_valid=1 and exe_to_mem_valid=1 -> mem_allowin=0 and bus_reg unchanged; after release, the new instruction is accepted on the same edge the old one leaves.
- Reset during a HELD load -> next cycle mem_valid=0, gr_we_mem=0, dest_mem=0, forward_data_mem=0, mem_allowin=1.

Source files
------------

// File: rtl/mem_stage_if.sv
// Handshake and bus bundle around the memory-access stage.
//   master : the pipeline around the stage (execute side, write-back, SRAM, decode)
//   slave  : mem_stage itself
// Signals:
//   exe_to_mem_valid / exe_to_mem_bus / mem_allowin : execute -> mem handshake
//   mem_to_wb_valid / mem_to_wb_bus / wb_allowin    : mem -> write-back handshake
//   data_sram_rdata                                 : SRAM read word, one cycle after the address
//   gr_we_mem / dest_mem / forward_data_mem         : bypass info for decode
// Valid/ready: a transfer happens on a rising edge where valid and the
// receiver's allowin are both 1; the sender holds valid and bus stable until then.
interface mem_stage_if;
  logic        exe_to_mem_valid;
  logic [77:0] exe_to_mem_bus;
  logic        mem_allowin;
  logic        wb_allowin;
  logic        mem_to_wb_valid;
  logic [69:0] mem_to_wb_bus;
  logic [31:0] data_sram_rdata;
  logic        gr_we_mem;
  logic [4:0]  dest_mem;
  logic [31:0] forward_data_mem;

  modport master (
    output exe_to_mem_valid, exe_to_mem_bus, wb_allowin, data_sram_rdata,
    input  mem_allowin, mem_to_wb_valid, mem_to_wb_bus,
           gr_we_mem, dest_mem, forward_data_mem
  );

  modport slave (
    input  exe_to_mem_valid, exe_to_mem_bus, wb_allowin, data_sram_rdata,
    output mem_allowin, mem_to_wb_valid, mem_to_wb_bus,
           gr_we_mem, dest_mem, forward_data_mem
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: latches the execute-to-memory bus, captures the
// synchronous data-SRAM read word, holds it across write-back stalls,
// extracts/extends load results and forwards the final value to decode.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   io            : mem_stage_if.slave bundle (handshakes, buses, SRAM data, bypass)
//   rd_state_o    : debug view of the read-word state (EMPTY/FRESH/HELD)
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  io,
  output logic [1:0]  rd_state_o
);

  localparam int EXE_TO_MEM_BUS_WD = 78;

  // EMPTY: no load in stage; FRESH: load's first cycle, word is on the SRAM
  // port; HELD: load stalled past its first cycle, word lives in rdata_buf_q.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FRESH = 2'd1,
    ST_HELD  = 2'd2
  } rd_state_e;

  rd_state_e                    state_q;
  logic                         mem_valid_q;
  logic [EXE_TO_MEM_BUS_WD-1:0] bus_reg_q;
  logic [31:0]                  rdata_buf_q;

  logic accept;
  logic mem_allowin;

  assign mem_allowin = !mem_valid_q || io.wb_allowin;
  assign accept      = io.exe_to_mem_valid && mem_allowin;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_q <= 1'b0;
      state_q     <= ST_EMPTY;
      rdata_buf_q <= 32'd0;
      bus_reg_q   <= '0;
    end else begin
      if (mem_allowin) begin
        mem_valid_q <= io.exe_to_mem_valid;
      end
      if (accept) begin
        bus_reg_q <= io.exe_to_mem_bus;
        state_q   <= io.exe_to_mem_bus[70] ? ST_FRESH : ST_EMPTY;
      end else if (state_q == ST_FRESH) begin
        // The SRAM word is only valid this one cycle; keep it for the stall.
        state_q     <= ST_HELD;
        rdata_buf_q <= io.data_sram_rdata;
      end
    end
  end

  // Field decode
  logic        ld_b, ld_bu, ld_h, ld_hu, ld_w;
  logic        load_op, gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result, pc;

  assign ld_b       = bus_reg_q[77];
  assign ld_bu      = bus_reg_q[76];
  assign ld_h       = bus_reg_q[75];
  assign ld_hu      = bus_reg_q[74];
  assign ld_w       = bus_reg_q[73];
  assign load_op    = bus_reg_q[70];
  assign gr_we      = bus_reg_q[69];
  assign dest       = bus_reg_q[68:64];
  assign alu_result = bus_reg_q[63:32];
  assign pc         = bus_reg_q[31:0];

  // signed_option and lu12i_w travel with the bus but have no role here.
  logic unused_fields;
  assign unused_fields = ^{bus_reg_q[72], bus_reg_q[71]};

  logic [31:0] raw_word;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign raw_word = (state_q == ST_FRESH) ? io.data_sram_rdata : rdata_buf_q;

  always_comb begin
    byte_lane = raw_word[7:0];
    case (alu_result[1:0])
      2'd0: byte_lane = raw_word[7:0];
      2'd1: byte_lane = raw_word[15:8];
      2'd2: byte_lane = raw_word[23:16];
      2'd3: byte_lane = raw_word[31:24];
      default: byte_lane = raw_word[7:0];
    endcase
  end

  // Halfword address bit 0 is ignored.
  assign half_lane = alu_result[1] ? raw_word[31:16] : raw_word[15:0];

  always_comb begin
    load_data = raw_word;
    if (ld_b)       load_data = {{24{byte_lane[7]}}, byte_lane};
    else if (ld_bu) load_data = {24'd0, byte_lane};
    else if (ld_h)  load_data = {{16{half_lane[15]}}, half_lane};
    else if (ld_hu) load_data = {16'd0, half_lane};
    else if (ld_w)  load_data = raw_word;
  end

  assign final_result = load_op ? load_data : alu_result;

  assign io.mem_allowin      = mem_allowin;
  assign io.mem_to_wb_valid  = mem_valid_q;
  assign io.mem_to_wb_bus    = {gr_we, dest, final_result, pc};
  assign io.gr_we_mem        = mem_valid_q ? gr_we : 1'b0;
  assign io.dest_mem         = mem_valid_q ? dest : 5'd0;
  assign io.forward_data_mem = mem_valid_q ? final_result : 32'd0;
  assign rd_state_o          = state_q;

endmodule
